io_port: RTL and testbench

IO_PORT -- requirements
Module: io_port

---
 rtl/io_port.sv | 158 +++++++++++++++
 tb/tb_io_port.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_port.sv
// Front-panel I/O port: debounced "enter" button completes IN requests by
// capturing the slide switches, and an 8-digit multiplexed hex display shows OUT data.
module io_port #(
  parameter int DEB_CYCLES = 16,
  parameter int SCAN_DIV   = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        exec,
  input  logic [1:0]  ledout,
  input  logic        switchin,
  input  logic [15:0] out_data,
  input  logic [3:0]  out_addr,
  input  logic [15:0] sw_raw,
  input  logic        btn_raw,
  output logic [15:0] in_data,
  output logic        in_done,
  output logic        stall,
  output logic [7:0]  digit_sel,
  output logic [7:0]  seg
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  logic [15:0]   sw_s1, sw_s2;
  logic          btn_s1, btn_s2;
  logic [DW-1:0] deb_cnt;
  logic          btn_db, btn_db_q;
  logic          press;
  state_t        state_q, state_d;
  logic [15:0]   disp_data;
  logic [3:0]    disp_addr;
  logic          addr_vis;
  logic [SW-1:0] div_cnt;
  logic [2:0]    idx;
  logic [3:0]    cur_nib;
  logic          cur_blank;

  always_ff @(posedge clock) begin
    if (reset) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      sw_s1  <= sw_raw;
      sw_s2  <= sw_s1;
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
    end
  end

  // Counter runs only while the synced level disagrees with the accepted one,
  // so any bounce back to the old level restarts the qualification window.
  always_ff @(posedge clock) begin
    if (reset) begin
      deb_cnt  <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_s2 == btn_db)
        deb_cnt <= '0;
      else if (deb_cnt == DW'(DEB_CYCLES - 1))
        btn_db <= btn_s2;
      else
        deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign press = btn_db & ~btn_db_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (exec && switchin) state_d = WAIT;
      WAIT: if (press)            state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      in_done <= 1'b0;
      in_data <= '0;
    end else begin
      state_q <= state_d;
      in_done <= (state_q == WAIT) && press;
      if ((state_q == WAIT) && press)
        in_data <= sw_s2;
    end
  end

  assign stall = (state_q == WAIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      disp_data <= '0;
      disp_addr <= '0;
      addr_vis  <= 1'b0;
    end else if (exec && ledout[1]) begin
      disp_data <= out_data;
      addr_vis  <= ledout[0];
      if (ledout[0])
        disp_addr <= out_addr;
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_blank = 1'b1;
    if (!idx[2]) begin
      cur_nib   = disp_data[{idx[1:0], 2'b00} +: 4];
      cur_blank = 1'b0;
    end else if (idx == 3'd4 && addr_vis) begin
      cur_nib   = disp_addr;
      cur_blank = 1'b0;
    end
  end

  function automatic logic [7:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;
      4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;
      4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;
      4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;
      4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
    endcase
  endfunction

  // seg and digit_sel are loaded together from the same index, so a
  // mismatched pair can never be seen on the pins.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt   <= '0;
      idx       <= '0;
      digit_sel <= 8'hFE;
      seg       <= 8'hC0;
    end else begin
      if (div_cnt == SW'(SCAN_DIV - 1)) begin
        div_cnt <= '0;
        idx     <= idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      digit_sel <= ~(8'b1 << idx);
      seg       <= cur_blank ? 8'hFF : hex7(cur_nib);
    end
  end

endmodule

// File: tb/tb_io_port.sv
// Randomized scoreboard bench for io_port: IN captures are queued when a
// qualifying press is issued and popped by a monitor on in_done.
module tb_io_port;
  localparam int DEB = 16;
  localparam int SDIV = 16;

  logic        clock = 1'b0;
  logic        reset, exec, switchin, btn_raw;
  logic [1:0]  ledout;
  logic [15:0] out_data, sw_raw, in_data;
  logic [3:0]  out_addr;
  logic        in_done, stall;
  logic [7:0]  digit_sel, seg;

  io_port #(.DEB_CYCLES(DEB), .SCAN_DIV(SDIV)) dut (
    .clock(clock), .reset(reset), .exec(exec), .ledout(ledout),
    .switchin(switchin), .out_data(out_data), .out_addr(out_addr),
    .sw_raw(sw_raw), .btn_raw(btn_raw), .in_data(in_data),
    .in_done(in_done), .stall(stall), .digit_sel(digit_sel), .seg(seg)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0, done_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  logic [7:0]  hex_tab [16];
  logic [15:0] m_data;
  logic [3:0]  m_addr;
  logic        m_vis;

  // Monitor: every in_done must match the oldest expected capture.
  always @(negedge clock) begin
    if (in_done === 1'b1) begin
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_in_done: in_data=%h, no capture was expected", in_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (in_data !== mon_exp) begin
          errors++;
          $display("FAIL in_data: got %h, expected %h", in_data, mon_exp);
        end
      end
      checks++;
      if (stall !== 1'b0) begin
        errors++;
        $display("FAIL stall_in_done_cycle: got %b, expected 0", stall);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
    m_data = '0; m_addr = '0; m_vis = 1'b0;
  endtask

  task automatic do_exec(input logic sin, input logic [1:0] lo,
                         input logic [15:0] d, input logic [3:0] a);
    exec = 1'b1; switchin = sin; ledout = lo; out_data = d; out_addr = a;
    tick();
    exec = 1'b0; switchin = 1'b0; ledout = 2'b00;
    if (lo[1]) begin
      m_data = d;
      m_vis  = lo[0];
      if (lo[0]) m_addr = a;
    end
  endtask

  task automatic press(input int n);
    btn_raw = 1'b1;
    tick(n);
    btn_raw = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int k;
    k = 0;
    while (done_cnt < target && k < 80) begin tick(); k++; end
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL %s timeout: in_done count %0d, expected %0d", name, done_cnt, target);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int k);
    if (k < 4)               return hex_tab[m_data[4*k +: 4]];
    else if (k == 4 && m_vis) return hex_tab[m_addr];
    else                     return 8'hFF;
  endfunction

  task automatic check_scan(input string name, input int slots);
    logic [7:0] want;
    int k;
    tick(2);
    for (int s = 0; s < slots; s++) begin
      want = ~(8'h01 << s);
      k = 0;
      while (digit_sel !== want && k < 10 * SDIV) begin tick(); k++; end
      if (digit_sel !== want) begin
        checks++; errors++;
        $display("FAIL %s slot%0d digit_sel timeout: got %h, expected %h", name, s, digit_sel, want);
      end else begin
        chk($sformatf("%s slot%0d seg", name, s), {8'h00, seg}, {8'h00, exp_seg(s)});
      end
    end
  endtask

  initial begin
    int base;
    logic [15:0] v;
    hex_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    exec = 0; switchin = 0; ledout = 0; out_data = 0; out_addr = 0;
    sw_raw = 0; btn_raw = 0; reset = 1;
    m_data = 0; m_addr = 0; m_vis = 0;

    // reset state, sampled while reset is held
    tick(3);
    chk("reset digit_sel", {8'h00, digit_sel}, 16'h00FE);
    chk("reset seg", {8'h00, seg}, 16'h00C0);
    chk("reset stall", {15'b0, stall}, 16'h0);
    chk("reset in_done", {15'b0, in_done}, 16'h0);
    chk("reset in_data", in_data, 16'h0);
    do_reset(1);

    // basic IN with a full-length press
    sw_raw = 16'hA5C3; tick(3);
    do_exec(1'b1, 2'b00, 16'h0, 4'h0);
    chk("stall after exec", {15'b0, stall}, 16'h1);
    exp_q.push_back(16'hA5C3);
    base = done_cnt;
    press(20);
    wait_done(base + 1, "basic capture");
    tick(25);

    // short pulses are filtered; exec+switchin during WAIT ignored
    sw_raw = 16'h1357; tick(3);
    do_exec(1'b1, 2'b00, 16'h0, 4'h0);
    base = done_cnt;
    repeat (3) begin press(10); tick(10); end
    do_exec(1'b1, 2'b00, 16'h0, 4'h0);
    tick(20);
    chk("short pulses no done", done_cnt[15:0], base[15:0]);
    chk("short pulses stall", {15'b0, stall}, 16'h1);
    exp_q.push_back(16'h1357);
    press(20);
    wait_done(base + 1, "after short pulses");
    tick(25);
    chk("single capture", done_cnt[15:0], 16'(base + 1));

    // press in IDLE has no effect
    base = done_cnt;
    press(20); tick(25);
    chk("idle press", done_cnt[15:0], base[15:0]);

    // reset in WAIT aborts without in_done; later press ignored
    sw_raw = 16'hBEEF; tick(3);
    do_exec(1'b1, 2'b00, 16'h0, 4'h0);
    tick(5);
    do_reset(2);
    chk("stall after reset", {15'b0, stall}, 16'h0);
    press(20); tick(25);
    chk("no done after reset", done_cnt[15:0], base[15:0]);

    // held button through IN entry needs release and a fresh press
    sw_raw = 16'h0F0F;
    btn_raw = 1'b1; tick(25);
    do_exec(1'b1, 2'b00, 16'h0, 4'h0);
    tick(30);
    chk("held no done", done_cnt[15:0], base[15:0]);
    chk("held stall", {15'b0, stall}, 16'h1);
    btn_raw = 1'b0; tick(25);
    exp_q.push_back(16'h0F0F);
    press(18);
    wait_done(base + 1, "fresh press");
    tick(25);

    // randomized IN transactions
    for (int i = 0; i < 6; i++) begin
      v = 16'($urandom);
      sw_raw = v; tick(3);
      do_exec(1'b1, 2'b00, 16'h0, 4'h0);
      base = done_cnt;
      press($urandom_range(2, 10)); tick(25);
      chk("rand short stall", {15'b0, stall}, 16'h1);
      exp_q.push_back(v);
      press($urandom_range(20, 30));
      wait_done(base + 1, "rand capture");
      tick(25);
    end

    // display
    do_exec(1'b0, 2'b11, 16'h1234, 4'h7);
    check_scan("out addr", 8);
    do_exec(1'b0, 2'b10, 16'h00FF, 4'h3);
    check_scan("out noaddr", 5);
    do_exec(1'b0, 2'b01, 16'hDEAD, 4'h9);
    check_scan("no ledout1", 5);
    for (int i = 0; i < 3; i++) begin
      do_exec(1'b0, {1'b1, 1'($urandom)}, 16'($urandom), 4'($urandom));
      check_scan("rand out", 8);
    end

    // IN and OUT together
    sw_raw = 16'h6C1E; tick(3);
    do_exec(1'b1, 2'b11, 16'h9AB0, 4'hC);
    chk("combo stall", {15'b0, stall}, 16'h1);
    check_scan("combo", 5);
    base = done_cnt;
    exp_q.push_back(16'h6C1E);
    press(20);
    wait_done(base + 1, "combo capture");
    tick(25);

    chk("scoreboard drained", 16'(exp_q.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
